// File: rtl/lane_phase_scheduler.sv
// Demand-driven green-phase scheduler for a four-lane intersection.
// Round-robin service, one congestion extension, emergency preemption.
module lane_phase_scheduler #(
    parameter int T_GREEN     = 20,
    parameter int T_GREEN_EXT = 10,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] cong,
    input  logic [3:0] emerg,
    output logic [3:0] grant,
    output logic [1:0] NS_light,
    output logic [1:0] SN_light,
    output logic [1:0] EW_light,
    output logic [1:0] WE_light,
    output logic [2:0] phase_state,
    output logic       emerg_active
);

    typedef enum logic [2:0] {
        S_ALLRED = 3'b000,
        S_GREEN  = 3'b001,
        S_YELLOW = 3'b010,
        S_EMERG  = 3'b011
    } state_t;

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_EXT    = CNT_W'(T_GREEN_EXT - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);

    state_t           state, n_state;
    logic [CNT_W-1:0] timer, n_timer;
    logic [3:0]       pending, n_pending;
    logic [1:0]       cur, n_cur;
    logic [1:0]       last, n_last;
    logic             ext_used, n_ext;
    logic [3:0]       start;
    logic [3:0]       n_grant;
    logic [1:0]       n_lt [4];

    logic             expired;
    logic [3:0]       demand;
    logic             rr_hit;
    logic [1:0]       rr_lane;
    logic [1:0]       em_lane;
    logic [1:0]       idx;

    assign expired = (timer == '0);
    assign demand  = pending | req;

    // Round-robin pick starting after the last normally served lane,
    // and lowest-index emergency lane.
    always_comb begin
        rr_hit  = 1'b0;
        rr_lane = 2'd0;
        idx     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!rr_hit && demand[idx]) begin
                rr_hit  = 1'b1;
                rr_lane = idx;
            end
        end
        em_lane = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (emerg[k]) em_lane = 2'(k);
        end
    end

    // Next-state, timer and arbitration decisions.
    always_comb begin
        n_state = state;
        n_timer = expired ? timer : timer - 1'b1;
        n_cur   = cur;
        n_last  = last;
        n_ext   = ext_used;
        start   = 4'b0000;
        case (state)
            S_ALLRED: begin
                if (expired && (|emerg)) begin
                    n_state = S_EMERG;
                    n_cur   = em_lane;
                    n_timer = timer;
                    start   = 4'b0001 << em_lane;
                end else if (expired && rr_hit) begin
                    n_state = S_GREEN;
                    n_timer = LD_GREEN;
                    n_cur   = rr_lane;
                    n_last  = rr_lane;
                    n_ext   = 1'b0;
                    start   = 4'b0001 << rr_lane;
                end
            end
            S_GREEN: begin
                if (emerg[cur]) begin
                    n_state = S_EMERG;
                    n_timer = timer;
                    start   = 4'b0001 << cur;
                end else if (|emerg) begin
                    n_state = S_YELLOW;
                    n_timer = LD_YELLOW;
                end else if (expired) begin
                    if (cong[cur] && !ext_used) begin
                        n_timer = LD_EXT;
                        n_ext   = 1'b1;
                    end else begin
                        n_state = S_YELLOW;
                        n_timer = LD_YELLOW;
                    end
                end
            end
            S_YELLOW: begin
                if (expired) begin
                    n_state = S_ALLRED;
                    n_timer = LD_ALLRED;
                end
            end
            S_EMERG: begin
                n_timer = timer;
                if (!emerg[cur]) begin
                    n_state = S_YELLOW;
                    n_timer = LD_YELLOW;
                end
            end
            default: begin
                n_state = S_ALLRED;
                n_timer = LD_ALLRED;
            end
        endcase
        n_pending = (pending | req) & ~start;
    end

    // Output values as they will appear in the next state.
    always_comb begin
        n_grant = (n_state == S_ALLRED) ? 4'b0000 : (4'b0001 << n_cur);
        for (int i = 0; i < 4; i++) begin
            n_lt[i] = 2'b00;
            if (n_grant[i]) begin
                n_lt[i] = (n_state == S_YELLOW) ? 2'b01 : 2'b10;
            end
        end
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_ALLRED;
            timer        <= LD_ALLRED;
            pending      <= 4'b0000;
            cur          <= 2'd0;
            last         <= 2'd3;
            ext_used     <= 1'b0;
            grant        <= 4'b0000;
            NS_light     <= 2'b00;
            SN_light     <= 2'b00;
            EW_light     <= 2'b00;
            WE_light     <= 2'b00;
            phase_state  <= 3'b000;
            emerg_active <= 1'b0;
        end else begin
            state        <= n_state;
            timer        <= n_timer;
            pending      <= n_pending;
            cur          <= n_cur;
            last         <= n_last;
            ext_used     <= n_ext;
            grant        <= n_grant;
            NS_light     <= n_lt[0];
            SN_light     <= n_lt[1];
            EW_light     <= n_lt[2];
            WE_light     <= n_lt[3];
            phase_state  <= n_state;
            emerg_active <= (n_state == S_EMERG);
        end
    end

endmodule

// File: tb/tb_lane_phase_scheduler.sv
// Bench for lane_phase_scheduler: directed table, corner sequences,
// and randomized traffic against a segment-based reference model.
module tb_lane_phase_scheduler;

    localparam int TG  = 20;
    localparam int TGE = 10;
    localparam int TY  = 3;
    localparam int TAR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, cong, emerg;
    logic [3:0] grant;
    logic [1:0] NS_light, SN_light, EW_light, WE_light;
    logic [2:0] phase_state;
    logic       emerg_active;

    int errs = 0;
    int checks = 0;

    lane_phase_scheduler #(
        .T_GREEN(TG), .T_GREEN_EXT(TGE), .T_YELLOW(TY),
        .T_ALLRED(TAR), .CNT_W(6)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .cong(cong), .emerg(emerg),
        .grant(grant), .NS_light(NS_light), .SN_light(SN_light),
        .EW_light(EW_light), .WE_light(WE_light),
        .phase_state(phase_state), .emerg_active(emerg_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h expected=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lights_of(input int ph,
                                             input logic [3:0] gr);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (gr[i]) r[7-2*i -: 2] = (ph == 2) ? 2'b01 : 2'b10;
        end
        return r;
    endfunction

    // Reference model: phase segments measured in elapsed cycles.
    // ph: 0 all-red, 1 green, 2 yellow, 3 emergency green.
    int m_ph, m_lane, m_last, m_el, m_lim, m_ext;
    int m_pend [4];

    function automatic void m_reset();
        m_ph = 0; m_lane = 0; m_last = 3;
        m_el = 0; m_lim = TAR; m_ext = 0;
        for (int i = 0; i < 4; i++) m_pend[i] = 0;
    endfunction

    function automatic void m_step();
        int st, nel, l;
        bit done, found;
        st = -1;
        nel = m_el + 1;
        done = (m_el >= m_lim - 1);
        case (m_ph)
            0: if (done) begin
                if (emerg != 4'b0) begin
                    l = 0;
                    for (int i = 3; i >= 0; i--) if (emerg[i]) l = i;
                    m_ph = 3; m_lane = l; st = l; nel = 0;
                end else begin
                    found = 0;
                    for (int k = 1; k <= 4; k++) begin
                        l = (m_last + k) % 4;
                        if (!found && (m_pend[l] != 0 || req[l])) begin
                            found = 1;
                            m_ph = 1; m_lane = l; m_last = l;
                            m_ext = 0; m_lim = TG; st = l; nel = 0;
                        end
                    end
                end
            end
            1: begin
                if (emerg[m_lane]) begin
                    m_ph = 3; st = m_lane; nel = 0;
                end else if (emerg != 4'b0) begin
                    m_ph = 2; m_lim = TY; nel = 0;
                end else if (done) begin
                    if (cong[m_lane] && m_ext == 0) begin
                        m_ext = 1; m_lim = TGE; nel = 0;
                    end else begin
                        m_ph = 2; m_lim = TY; nel = 0;
                    end
                end
            end
            2: if (done) begin
                m_ph = 0; m_lim = TAR; nel = 0;
            end
            default: if (!emerg[m_lane]) begin
                m_ph = 2; m_lim = TY; nel = 0;
            end
        endcase
        m_el = nel;
        for (int i = 0; i < 4; i++)
            m_pend[i] = ((m_pend[i] != 0 || req[i]) && st != i) ? 1 : 0;
    endfunction

    function automatic logic [3:0] m_grant();
        return (m_ph == 0) ? 4'b0 : (4'b0001 << m_lane);
    endfunction

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_grant"}, grant, m_grant());
        chk({tag, "_lights"}, {NS_light, SN_light, EW_light, WE_light},
            lights_of(m_ph, m_grant()));
        chk({tag, "_phase"}, phase_state, m_ph);
        chk({tag, "_emact"}, emerg_active, m_ph == 3);
    endtask

    typedef struct {
        int         n;
        logic [3:0] rq;
        logic [3:0] cg;
        logic [3:0] em;
        logic [2:0] ph;
        logic [3:0] gr;
    } vec_t;

    vec_t vt [$];

    initial begin
        int g, y, hold;
        vt.push_back('{10, 4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000});
        vt.push_back('{1,  4'b0100, 4'b0000, 4'b0000, 3'd1, 4'b0100});
        vt.push_back('{19, 4'b0000, 4'b0000, 4'b0000, 3'd1, 4'b0100});
        vt.push_back('{1,  4'b0000, 4'b0000, 4'b0000, 3'd2, 4'b0100});
        vt.push_back('{2,  4'b0000, 4'b0000, 4'b0000, 3'd2, 4'b0100});
        vt.push_back('{1,  4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000});
        vt.push_back('{6,  4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000});
        vt.push_back('{1,  4'b0000, 4'b0000, 4'b1000, 3'd3, 4'b1000});
        vt.push_back('{3,  4'b0000, 4'b0000, 4'b1000, 3'd3, 4'b1000});
        vt.push_back('{1,  4'b0000, 4'b0000, 4'b0000, 3'd2, 4'b1000});
        vt.push_back('{3,  4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000});
        vt.push_back('{1,  4'b0001, 4'b0000, 4'b0000, 3'd0, 4'b0000});
        vt.push_back('{1,  4'b0000, 4'b0000, 4'b0000, 3'd1, 4'b0001});
        vt.push_back('{4,  4'b0000, 4'b0000, 4'b0000, 3'd1, 4'b0001});
        vt.push_back('{1,  4'b0000, 4'b0000, 4'b1000, 3'd2, 4'b0001});
        vt.push_back('{2,  4'b0000, 4'b0000, 4'b1000, 3'd2, 4'b0001});
        vt.push_back('{2,  4'b0000, 4'b0000, 4'b1000, 3'd0, 4'b0000});
        vt.push_back('{1,  4'b0000, 4'b0000, 4'b1000, 3'd3, 4'b1000});
        vt.push_back('{1,  4'b0000, 4'b0000, 4'b0000, 3'd2, 4'b1000});

        rst = 1'b0; req = '0; cong = '0; emerg = '0;
        m_reset();
        #12;
        chk("reset_grant", grant, 4'b0);
        chk("reset_lights", {NS_light, SN_light, EW_light, WE_light}, 8'h00);
        chk("reset_phase", phase_state, 3'd0);
        chk("reset_emact", emerg_active, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        foreach (vt[v]) begin
            req = vt[v].rq; cong = vt[v].cg; emerg = vt[v].em;
            repeat (vt[v].n) tick();
            chk($sformatf("vec%0d_phase", v), phase_state, vt[v].ph);
            chk($sformatf("vec%0d_grant", v), grant, vt[v].gr);
            chk($sformatf("vec%0d_lights", v),
                {NS_light, SN_light, EW_light, WE_light},
                lights_of(vt[v].ph, vt[v].gr));
        end
        req = '0; emerg = '0;

        // Congested lane 0: exactly one extension.
        repeat (6) tick();
        cong = 4'b0001; req = 4'b0001;
        tick();
        req = '0;
        g = 0;
        for (int i = 0; i < 100; i++) begin
            if (NS_light == 2'b10) g++;
            else if (g > 0) break;
            tick();
        end
        y = 0;
        for (int i = 0; i < 10 && NS_light == 2'b01; i++) begin
            y++;
            tick();
        end
        chk("cong_green_len", g, TG + TGE);
        chk("cong_yellow_len", y, TY);
        cong = '0;

        // Emergency on the lane currently green: no clearance.
        req = 4'b0010;
        tick();
        req = '0;
        hold = 0;
        while (grant != 4'b0010 && hold < 40) begin
            tick();
            hold++;
        end
        chk("emself_wait", hold < 40, 1'b1);
        repeat (3) tick();
        emerg = 4'b0010;
        tick();
        chk("emself_phase", phase_state, 3'd3);
        chk("emself_light", SN_light, 2'b10);
        repeat (30) tick();
        chk("emself_hold", {phase_state, SN_light}, {3'd3, 2'b10});
        emerg = '0;
        tick();
        chk("emself_yellow", {phase_state, SN_light}, {3'd2, 2'b01});
        repeat (TY) tick();
        chk("emself_allred", phase_state, 3'd0);

        // Async reset in the middle of lane 2 yellow.
        req = 4'b0100;
        tick();
        req = '0;
        hold = 0;
        while (EW_light != 2'b01 && hold < 60) begin
            tick();
            hold++;
        end
        chk("rst_reach_yellow", EW_light, 2'b01);
        tick();
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        chk("async_rst_outs",
            {grant, NS_light, SN_light, EW_light, WE_light,
             phase_state, emerg_active}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1;
        req = 4'b1111;
        tick();
        req = '0;
        tick();
        chk("rst_first_lane", grant, 4'b0001);
        chk_model("post_rst");

        // Randomized traffic against the model.
        hold = 0;
        for (int c = 0; c < 5000; c++) begin
            if (hold > 0) begin
                hold--;
                if (hold == 0) emerg = '0;
            end else if ($urandom_range(0, 149) == 0) begin
                emerg = 4'(1 << $urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0)
                    emerg = emerg | 4'(1 << $urandom_range(0, 3));
                hold = $urandom_range(3, 40);
            end
            req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 19) == 0) cong = 4'($urandom);
            tick();
            chk_model("rand");
            chk("rand_onehot", $countones(grant) <= 1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
